// File: rtl/length_counter_bank.sv
// Bank of NUM_CH APU length counters sharing one half-frame tick, one
// length-table lookup and one indexed CPU write port. Drives the per-channel
// "active" vector and a debug count read-back.
// Optional build macro: LC_RELOAD_RACE_EN -- when defined, a reload that
// coincides with a decrement of a non-zero count is dropped (2A03 behaviour).
module length_counter_bank #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CH_W   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_en,
   input  logic              half_frame,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [4:0]        wr_index,
   input  logic [NUM_CH-1:0] halt,
   input  logic [NUM_CH-1:0] enable,
   output logic [NUM_CH-1:0] active,
   input  logic [CH_W-1:0]   rd_ch,
   output logic [7:0]        rd_count
);

   localparam int unsigned CNT_W = 8;

   logic [CNT_W-1:0]  count     [NUM_CH];
   logic [CNT_W-1:0]  count_nxt [NUM_CH];
   logic [CNT_W-1:0]  lut_val;
   logic [NUM_CH-1:0] load_vec;
   logic [NUM_CH-1:0] dec_vec;

   // Shared length table lookup for the single write port
   always_comb begin
      lut_val = 8'd0;
      case (wr_index)
         5'd0:  lut_val = 8'd10;
         5'd1:  lut_val = 8'd254;
         5'd2:  lut_val = 8'd20;
         5'd3:  lut_val = 8'd2;
         5'd4:  lut_val = 8'd40;
         5'd5:  lut_val = 8'd4;
         5'd6:  lut_val = 8'd80;
         5'd7:  lut_val = 8'd6;
         5'd8:  lut_val = 8'd160;
         5'd9:  lut_val = 8'd8;
         5'd10: lut_val = 8'd60;
         5'd11: lut_val = 8'd10;
         5'd12: lut_val = 8'd14;
         5'd13: lut_val = 8'd12;
         5'd14: lut_val = 8'd26;
         5'd15: lut_val = 8'd14;
         5'd16: lut_val = 8'd12;
         5'd17: lut_val = 8'd16;
         5'd18: lut_val = 8'd24;
         5'd19: lut_val = 8'd18;
         5'd20: lut_val = 8'd48;
         5'd21: lut_val = 8'd20;
         5'd22: lut_val = 8'd96;
         5'd23: lut_val = 8'd22;
         5'd24: lut_val = 8'd192;
         5'd25: lut_val = 8'd24;
         5'd26: lut_val = 8'd72;
         5'd27: lut_val = 8'd26;
         5'd28: lut_val = 8'd16;
         5'd29: lut_val = 8'd28;
         5'd30: lut_val = 8'd32;
         5'd31: lut_val = 8'd30;
         default: lut_val = 8'd0;
      endcase
   end

   // Per-channel load select and decrement qualifier; out-of-range wr_ch matches nothing
   always_comb begin
      load_vec = '0;
      dec_vec  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         load_vec[i] = wr_en && (wr_ch == CH_W'(i));
         dec_vec[i]  = half_frame && !halt[i] && (count[i] != 8'd0);
      end
   end

   // Next count per channel: disable clears, then load, then saturating decrement
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         count_nxt[i] = count[i];
         if (!enable[i]) begin
            count_nxt[i] = 8'd0;
`ifdef LC_RELOAD_RACE_EN
         end else if (load_vec[i] && dec_vec[i]) begin
            count_nxt[i] = CNT_W'(count[i] - 8'd1);
`endif
         end else if (load_vec[i]) begin
            count_nxt[i] = lut_val;
         end else if (dec_vec[i]) begin
            count_nxt[i] = CNT_W'(count[i] - 8'd1);
         end
      end
   end

   // Count registers: reset overrides cpu_en, otherwise update only on cpu_en
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (reset) begin
            count[i] <= 8'd0;
         end else if (cpu_en) begin
            count[i] <= count_nxt[i];
         end
      end
   end

   // Channel gating / status bits straight from the counts
   always_comb begin
      active = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         active[i] = (count[i] != 8'd0);
      end
   end

   // Debug read mux; unmatched selects read as zero
   always_comb begin
      rd_count = 8'd0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (rd_ch == CH_W'(i)) begin
            rd_count = count[i];
         end
      end
   end

endmodule

// File: tb/tb_length_counter_bank.sv
// Scoreboard bench for length_counter_bank: a 4-channel instance with 3-bit
// selects (so out-of-range channels are reachable) and a 1-channel instance.
module tb_length_counter_bank;

`ifdef LC_RELOAD_RACE_EN
   localparam bit RACE = 1'b1;
`else
   localparam bit RACE = 1'b0;
`endif

   typedef logic [3:0][7:0] cnt_t;

   logic       clk = 1'b0;
   logic       reset, cpu_en, half_frame, wr_en;
   logic [2:0] wr_ch, rd_ch;
   logic [4:0] wr_index;
   logic [3:0] halt, enable, active;
   logic [7:0] rd_count;

   logic       reset1, wr_en1, half1;
   logic [0:0] wr_ch1, rd_ch1, halt1, enable1, active1;
   logic [7:0] rd_count1;

   int errors = 0;
   int checks = 0;
   cnt_t mdl;
   cnt_t exp_q[$];
   int unsigned lut [32] = '{10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,
                             12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30};

   length_counter_bank #(.NUM_CH(4), .CH_W(3)) u_dut (
      .clk(clk), .reset(reset), .cpu_en(cpu_en), .half_frame(half_frame),
      .wr_en(wr_en), .wr_ch(wr_ch), .wr_index(wr_index), .halt(halt),
      .enable(enable), .active(active), .rd_ch(rd_ch), .rd_count(rd_count)
   );

   length_counter_bank #(.NUM_CH(1), .CH_W(1)) u_dut1 (
      .clk(clk), .reset(reset1), .cpu_en(cpu_en), .half_frame(half1),
      .wr_en(wr_en1), .wr_ch(wr_ch1), .wr_index(wr_index), .halt(halt1),
      .enable(enable1), .active(active1), .rd_ch(rd_ch1), .rd_count(rd_count1)
   );

   always #20 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference behaviour of one cpu clock edge (reset handled separately)
   function automatic cnt_t model_next(input cnt_t cur, input logic ce, input logic hf,
                                       input logic we, input logic [2:0] wch,
                                       input logic [4:0] widx, input logic [3:0] h,
                                       input logic [3:0] en);
      cnt_t nxt = cur;
      if (!ce) return cur;
      for (int c = 0; c < 4; c++) begin
         bit tick;
         bit hit;
         tick = hf && !h[c] && (cur[c] != 8'd0);
         hit  = we && (int'(wch) == c);
         if (!en[c])                  nxt[c] = 8'd0;
         else if (hit && !(RACE && tick)) nxt[c] = 8'(lut[widx]);
         else if (tick)               nxt[c] = 8'(cur[c] - 8'd1);
      end
      return nxt;
   endfunction

   // Pop the expected state and compare every channel, an out-of-range read and active
   task automatic compare_out();
      cnt_t e;
      logic [3:0] ea;
      if (exp_q.size() == 0) begin
         errors++;
         checks++;
         $display("FAIL sb_empty: got 0 entries expected 1");
         return;
      end
      e = exp_q.pop_front();
      for (int c = 0; c < 4; c++) begin
         rd_ch = 3'(c);
         #1;
         check($sformatf("cnt%0d", c), rd_count, e[c]);
         ea[c] = (e[c] != 8'd0);
      end
      rd_ch = 3'd5;
      #1;
      check("rd_oor", rd_count, 0);
      check("active", active, ea);
   endtask

   task automatic step(input logic ce, input logic hf, input logic we,
                       input logic [2:0] wch, input logic [4:0] widx);
      @(negedge clk);
      reset = 1'b0; cpu_en = ce; half_frame = hf; wr_en = we; wr_ch = wch; wr_index = widx;
      mdl = model_next(mdl, ce, hf, we, wch, widx, halt, enable);
      exp_q.push_back(mdl);
      @(posedge clk);
      compare_out();
   endtask

   task automatic do_reset(input logic ce);
      @(negedge clk);
      reset = 1'b1; cpu_en = ce; half_frame = 1'b1; wr_en = 1'b1; wr_ch = 3'd1; wr_index = 5'd1;
      mdl = '0;
      exp_q.push_back(mdl);
      @(posedge clk);
      compare_out();
   endtask

   task automatic check_ch(input string tag, input logic [2:0] ch, input logic [7:0] val);
      rd_ch = ch;
      #1;
      check(tag, rd_count, val);
   endtask

   initial begin
      reset = 1'b1; cpu_en = 1'b0; half_frame = 1'b0; wr_en = 1'b0;
      wr_ch = 3'd0; rd_ch = 3'd0; wr_index = 5'd0; halt = 4'h0; enable = 4'h0;
      reset1 = 1'b1; wr_en1 = 1'b0; half1 = 1'b0; wr_ch1 = 1'b0; rd_ch1 = 1'b0;
      halt1 = 1'b0; enable1 = 1'b1;
      mdl = '0;

      do_reset(1'b1);
      check("rst_active", active, 4'b0000);
      reset1 = 1'b0;

      // Long count on ch1, saturation at zero
      enable = 4'hF;
      step(1, 0, 1, 3'd1, 5'd1);
      check_ch("load254", 3'd1, 8'd254);
      check("active_ch1", active, 4'b0010);
      for (int k = 0; k < 254; k++) step(1, 1, 0, 3'd0, 5'd0);
      check_ch("drained", 3'd1, 8'd0);
      check("active_drained", active, 4'b0000);
      step(1, 1, 0, 3'd0, 5'd0);
      check_ch("no_wrap", 3'd1, 8'd0);

      // Halt freezes ch2
      step(1, 0, 1, 3'd2, 5'd24);
      halt[2] = 1'b1;
      for (int k = 0; k < 10; k++) step(1, 1, 0, 3'd0, 5'd0);
      check_ch("halt_hold", 3'd2, 8'd192);
      halt[2] = 1'b0;
      step(1, 1, 0, 3'd0, 5'd0);
      step(1, 1, 0, 3'd0, 5'd0);
      check_ch("halt_release", 3'd2, 8'd190);

      // Disable clears ch0 and blocks writes
      step(1, 0, 1, 3'd0, 5'd0);
      check_ch("ch0_load", 3'd0, 8'd10);
      enable[0] = 1'b0;
      step(1, 0, 0, 3'd0, 5'd0);
      check_ch("disable_clr", 3'd0, 8'd0);
      step(1, 0, 1, 3'd0, 5'd3);
      check_ch("disabled_wr", 3'd0, 8'd0);
      enable[0] = 1'b1;
      step(1, 0, 0, 3'd0, 5'd0);
      check_ch("reenabled", 3'd0, 8'd0);

      // Reload/decrement coincidence on ch3, ch2 decrements independently
      step(1, 0, 1, 3'd3, 5'd2);
      check_ch("ch3_20", 3'd3, 8'd20);
      step(1, 1, 1, 3'd3, 5'd5);
      check_ch("race", 3'd3, RACE ? 8'd19 : 8'd4);
      check_ch("indep_dec", 3'd2, 8'd189);
      enable[3] = 1'b0;
      step(1, 0, 0, 3'd0, 5'd0);
      enable[3] = 1'b1;
      step(1, 1, 1, 3'd3, 5'd5);
      check_ch("race_from0", 3'd3, 8'd4);

      // cpu_en low freezes everything; out-of-range write does nothing
      step(0, 1, 1, 3'd2, 5'd0);
      check_ch("ce_low", 3'd2, 8'd188);
      step(1, 0, 1, 3'd5, 5'd1);
      check_ch("oor_wr2", 3'd2, 8'd188);
      check_ch("oor_wr3", 3'd3, 8'd4);

      // Random traffic against the model
      for (int k = 0; k < 300; k++) begin
         halt = 4'($urandom);
         for (int c = 0; c < 4; c++) enable[c] = ($urandom_range(0, 9) != 0);
         step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) != 0,
              3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      end

      // Reset mid-count with cpu_en low
      enable = 4'hF; halt = 4'h0;
      step(1, 0, 1, 3'd0, 5'd8);
      do_reset(1'b0);
      check("rst_mid_active", active, 4'b0000);

      // Single-channel build
      @(negedge clk);
      reset = 1'b0; cpu_en = 1'b1; wr_en = 1'b0; half_frame = 1'b0;
      wr_en1 = 1'b1; wr_ch1 = 1'b0; wr_index = 5'd0;
      @(posedge clk); #1;
      check("one_load", rd_count1, 10);
      check("one_active", active1, 1'b1);
      @(negedge clk);
      wr_en1 = 1'b0; half1 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("one_dec", rd_count1, 7);
      rd_ch1 = 1'b1;
      #1;
      check("one_oor", rd_count1, 0);
      rd_ch1 = 1'b0;
      @(negedge clk);
      half1 = 1'b0; cpu_en = 1'b0; reset1 = 1'b1;
      @(posedge clk); #1;
      check("one_rst", rd_count1, 0);
      check("one_rst_active", active1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
